// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: issues one instruction-memory read per cycle,
// holds the request address across memory stalls, and drops data from a
// request that was in flight when a branch/jump redirect arrived.
module ifetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              fetch_en_i,
    input  logic              flush_i,
    input  logic              id_stall_i,
    output logic              mem_ren_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    input  logic              mem_stall_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              stall_o,
    output logic [31:0]       fetch_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MISS  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       fetch_cnt_q, fetch_cnt_d;
    logic              mem_ren;
    logic [ADDR_W-3:0] mem_addr;

    // Memory request: outstanding MISS/DROP requests keep the latched address.
    always_comb begin
        mem_ren  = 1'b0;
        mem_addr = pc_i[ADDR_W-1:2];
        case (state_q)
            FETCH: mem_ren = ~id_stall_i;
            MISS, DROP: begin
                mem_ren  = 1'b1;
                mem_addr = addr_q[ADDR_W-1:2];
            end
            default: mem_ren = 1'b0;
        endcase
        if (!rst_n) begin
            mem_ren = 1'b0;
        end
    end

    // Next state and output-register updates; flush beats decode stall beats delivery.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    inst_valid_d = 1'b0;
                end
                if (fetch_en_i) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (flush_i) begin
                    inst_valid_d = 1'b0;
                    if (mem_ren && mem_stall_i) begin
                        addr_d  = pc_i;
                        state_d = DROP;
                    end else if (!fetch_en_i) begin
                        state_d = IDLE;
                    end
                end else if (id_stall_i) begin
                    if (!fetch_en_i) begin
                        state_d = IDLE;
                    end
                end else if (mem_stall_i) begin
                    addr_d       = pc_i;
                    inst_valid_d = 1'b0;
                    state_d      = MISS;
                end else begin
                    inst_d       = mem_rdata_i;
                    inst_pc_d    = pc_i;
                    inst_valid_d = 1'b1;
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                    if (!fetch_en_i) begin
                        state_d = IDLE;
                    end
                end
            end
            MISS: begin
                if (flush_i) begin
                    inst_valid_d = 1'b0;
                    if (mem_stall_i) begin
                        state_d = DROP;
                    end else begin
                        state_d = fetch_en_i ? FETCH : IDLE;
                    end
                end else if (!mem_stall_i && !id_stall_i) begin
                    // Data arriving under a decode stall is simply re-read next
                    // cycle: the address is still held, so nothing is lost.
                    inst_d       = mem_rdata_i;
                    inst_pc_d    = addr_q;
                    inst_valid_d = 1'b1;
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                    state_d      = fetch_en_i ? FETCH : IDLE;
                end
            end
            DROP: begin
                inst_valid_d = 1'b0;
                if (!mem_stall_i) begin
                    state_d = fetch_en_i ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign mem_ren_o    = mem_ren;
    assign mem_addr_o   = mem_addr;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;
    assign fetch_cnt_o  = fetch_cnt_q;
    assign stall_o      = id_stall_i | (mem_ren & mem_stall_i) | (state_q == MISS)
                        | (state_q == DROP) | ~fetch_en_i;

endmodule
